// File: rtl/scan_frame_packer.sv
// Packs one 8-bit sample per scanned channel into ping-pong buffers and streams each scan as
// HDR0 HDR1 SEQ DATA[0..NUM_CH-1] CHECK through a show-ahead read port. Macro FRAME_CRC8_EN selects CRC-8.
module scan_frame_packer #(
  parameter int         NUM_CH = 24,
  parameter logic [7:0] HDR0   = 8'hAA,
  parameter logic [7:0] HDR1   = 8'h55
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sample_valid,
  input  logic [5:0] sample_addr,
  input  logic [7:0] sample_data,
  input  logic       tx_rdreq,
  output logic [7:0] tx_data,
  output logic       tx_empty,
  output logic       busy,
  output logic [7:0] overrun_cnt,
  output logic       frame_err
);

  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_SEQ, S_DATA, S_CSUM} state_t;

  localparam logic [5:0] LAST_ADDR = 6'(NUM_CH - 1);

  // Running check-byte update; the CRC variant is MSB-first, poly 0x07, no reflection.
  function automatic logic [7:0] chk_upd(input logic [7:0] acc, input logic [7:0] din);
    logic [7:0] c;
`ifdef FRAME_CRC8_EN
    c = acc ^ din;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
`else
    c = acc + din;
`endif
    return c;
  endfunction

  logic [7:0]        mem_r [0:127];
  logic [NUM_CH-1:0] mask_r, onehot_s, mask_upd_s;
  logic              cap_sel_r, send_sel_r;
  logic [7:0]        overrun_cnt_r;
  logic              frame_err_r;
  logic              wr_s, commit_s, accept_s, pop_s, release_s;

  state_t     state_r, state_nx;
  logic [5:0] idx_r, idx_nx, rd_idx_s;
  logic [7:0] chk_r, chk_nx, seq_r, seq_nx, tx_data_r, tx_data_nx, rd_byte_s;
  logic       tx_empty_r, busy_r;

  assign wr_s      = sample_valid && (sample_addr <= LAST_ADDR);
  assign commit_s  = wr_s && (sample_addr == LAST_ADDR);
  assign pop_s     = tx_rdreq && !tx_empty_r;
  assign release_s = (state_r == S_CSUM) && pop_s;
  assign accept_s  = commit_s && ((state_r == S_IDLE) || release_s);

  // Mask as it stands including the current write; addr 0 starts a fresh frame.
  always_comb begin
    onehot_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      onehot_s[i] = (sample_addr == 6'(i));
    end
    mask_upd_s = ((sample_addr == 6'd0) ? {NUM_CH{1'b0}} : mask_r) | onehot_s;
  end

  // Frame buffer storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[{cap_sel_r, sample_addr}] <= sample_data;
    end
  end

  // Capture bookkeeping: mask, buffer selection, overrun counting and frame error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_r        <= {NUM_CH{1'b0}};
      cap_sel_r     <= 1'b0;
      send_sel_r    <= 1'b0;
      overrun_cnt_r <= 8'd0;
      frame_err_r   <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      if (commit_s) begin
        mask_r      <= {NUM_CH{1'b0}};
        frame_err_r <= ~&mask_upd_s;
        if (accept_s) begin
          cap_sel_r  <= ~cap_sel_r;
          send_sel_r <= cap_sel_r;
        end else if (overrun_cnt_r != 8'hFF) begin
          overrun_cnt_r <= overrun_cnt_r + 8'd1;
        end
      end else if (wr_s) begin
        mask_r <= mask_upd_s;
      end
    end
  end

  // Show-ahead read of the next data byte from the buffer being sent.
  assign rd_idx_s  = (state_r == S_DATA) ? (idx_r + 6'd1) : 6'd0;
  assign rd_byte_s = mem_r[{send_sel_r, rd_idx_s}];

  // Sender next-state and next-byte selection.
  always_comb begin
    state_nx   = state_r;
    idx_nx     = idx_r;
    chk_nx     = chk_r;
    seq_nx     = seq_r;
    tx_data_nx = tx_data_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nx   = S_HDR0;
          tx_data_nx = HDR0;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_HDR0: begin
        if (pop_s) begin
          state_nx   = S_HDR1;
          tx_data_nx = HDR1;
        end else begin
          state_nx = S_HDR0;
        end
      end
      S_HDR1: begin
        if (pop_s) begin
          state_nx   = S_SEQ;
          tx_data_nx = seq_r;
        end else begin
          state_nx = S_HDR1;
        end
      end
      S_SEQ: begin
        if (pop_s) begin
          state_nx   = S_DATA;
          idx_nx     = 6'd0;
          chk_nx     = chk_upd(8'h00, seq_r);
          tx_data_nx = rd_byte_s;
        end else begin
          state_nx = S_SEQ;
        end
      end
      S_DATA: begin
        if (pop_s && (idx_r == LAST_ADDR)) begin
          state_nx   = S_CSUM;
          tx_data_nx = chk_upd(chk_r, tx_data_r);
        end else if (pop_s) begin
          idx_nx     = idx_r + 6'd1;
          chk_nx     = chk_upd(chk_r, tx_data_r);
          tx_data_nx = rd_byte_s;
        end else begin
          state_nx = S_DATA;
        end
      end
      S_CSUM: begin
        if (pop_s) begin
          seq_nx = seq_r + 8'd1;
          if (accept_s) begin
            state_nx   = S_HDR0;
            tx_data_nx = HDR0;
          end else begin
            state_nx   = S_IDLE;
            tx_data_nx = 8'h00;
          end
        end else begin
          state_nx = S_CSUM;
        end
      end
      default: begin
        state_nx   = S_IDLE;
        tx_data_nx = 8'h00;
      end
    endcase
  end

  // Sender state and registered read-port outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_IDLE;
      idx_r      <= 6'd0;
      chk_r      <= 8'h00;
      seq_r      <= 8'h00;
      tx_data_r  <= 8'h00;
      tx_empty_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nx;
      idx_r      <= idx_nx;
      chk_r      <= chk_nx;
      seq_r      <= seq_nx;
      tx_data_r  <= tx_data_nx;
      tx_empty_r <= (state_nx == S_IDLE);
      busy_r     <= (state_nx != S_IDLE);
    end
  end

  assign tx_data     = tx_data_r;
  assign tx_empty    = tx_empty_r;
  assign busy        = busy_r;
  assign overrun_cnt = overrun_cnt_r;
  assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_scan_frame_packer.sv
// Directed bench for scan_frame_packer: packet content, sequencing, overrun, frame errors and reset abort.
module tb_scan_frame_packer;

  logic       clk = 1'b0;
  logic       reset_n, sample_valid, tx_rdreq;
  logic [5:0] sample_addr;
  logic [7:0] sample_data;
  logic [7:0] tx_data, overrun_cnt;
  logic       tx_empty, busy, frame_err;

  int vecs = 0;
  int errs = 0;
  int ferr_pulses = 0;
  int n, bc, ferr_base;
  logic [7:0] d   [0:23];
  logic [7:0] pkt [0:63];

  scan_frame_packer dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_addr(sample_addr),
    .sample_data(sample_data), .tx_rdreq(tx_rdreq), .tx_data(tx_data), .tx_empty(tx_empty),
    .busy(busy), .overrun_cnt(overrun_cnt), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) ferr_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [5:0] a, input logic [7:0] v);
    sample_valid = 1'b1;
    sample_addr  = a;
    sample_data  = v;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic put_frame(input logic [7:0] off);
    for (int i = 0; i < 24; i++) begin
      d[i] = 8'(i) + off;
      put(6'(i), d[i]);
    end
  endtask

  // Reference check byte; the CRC form feeds one bit at a time.
  function automatic logic [7:0] ref_chk(input logic [7:0] sq);
    logic [7:0] a;
    logic [7:0] b;
`ifdef FRAME_CRC8_EN
    a = 8'h00;
    for (int k = -1; k < 24; k++) begin
      b = (k < 0) ? sq : d[k];
      for (int j = 7; j >= 0; j--) begin
        if (a[7] ^ b[j]) a = {a[6:0], 1'b0} ^ 8'h07;
        else a = {a[6:0], 1'b0};
      end
    end
`else
    a = sq;
    for (int k = 0; k < 24; k++) a = a + d[k];
`endif
    return a;
  endfunction

  task automatic collect();
    logic done;
    done = 1'b0;
    n = 0;
    bc = 0;
    tx_rdreq = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      if (tx_empty && n > 0) begin
        done = 1'b1;
      end else begin
        if (busy) bc++;
        if (!tx_empty) begin
          pkt[n] = tx_data;
          n++;
        end
        step();
      end
    end
    tx_rdreq = 1'b0;
    check("collect_done", 32'(done), 32'd1);
  endtask

  task automatic check_pkt(input logic [7:0] sq, input string tag);
    check({tag, "_len"}, n, 32'd28);
    check({tag, "_busy"}, bc, 32'd28);
    check({tag, "_hdr0"}, pkt[0], 8'hAA);
    check({tag, "_hdr1"}, pkt[1], 8'h55);
    check({tag, "_seq"}, pkt[2], sq);
    for (int i = 0; i < 24; i++) check($sformatf("%s_data%0d", tag, i), pkt[3+i], d[i]);
    check({tag, "_chk"}, pkt[27], ref_chk(sq));
  endtask

  initial begin
    reset_n = 1'b0;
    sample_valid = 1'b0;
    sample_addr = 6'd0;
    sample_data = 8'd0;
    tx_rdreq = 1'b0;
    step();
    step();
    check("rst_empty", tx_empty, 1'b1);
    check("rst_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_ovr", overrun_cnt, 8'd0);
    check("rst_ferr", frame_err, 1'b0);
    reset_n = 1'b1;
    step();

    // Frame 1 with tx_rdreq held high; first byte one cycle after the last strobe.
    ferr_base = ferr_pulses;
    tx_rdreq = 1'b1;
    put_frame(8'h01);
    check("f1_latency_empty", tx_empty, 1'b0);
    check("f1_latency_hdr", tx_data, 8'hAA);
    collect();
    check_pkt(8'h00, "f1");
`ifndef FRAME_CRC8_EN
    check("f1_chk_const", pkt[27], 8'h2C);
`endif
    check("f1_no_ferr", ferr_pulses - ferr_base, 32'd0);

    put_frame(8'h01);
    collect();
    check_pkt(8'h01, "f2");
`ifndef FRAME_CRC8_EN
    check("f2_chk_const", pkt[27], 8'h2D);
`endif
    put_frame(8'h01);
    collect();
    check_pkt(8'h02, "f3");
`ifndef FRAME_CRC8_EN
    check("f3_chk_const", pkt[27], 8'h2E);
`endif

    // Second frame completes while the first is stalled: dropped and counted.
    put_frame(8'h01);
    check("ovr_busy", busy, 1'b1);
    for (int i = 0; i < 24; i++) put(6'(i), 8'h40 + 8'(i));
    check("ovr_cnt", overrun_cnt, 8'd1);
    collect();
    check_pkt(8'h03, "ovr");
    tx_rdreq = 1'b1;
    repeat (5) step();
    tx_rdreq = 1'b0;
    check("ovr_single_pkt", tx_empty, 1'b1);
    put_frame(8'h10);
    collect();
    check_pkt(8'h04, "reuse");

    // Missing addr 5: that slot keeps its stale value 0x06 from the overrun-test frame.
    ferr_base = ferr_pulses;
    for (int i = 0; i < 24; i++) begin
      d[i] = 8'h80 + 8'(i);
      if (i != 5) put(6'(i), d[i]);
    end
    d[5] = 8'h06;
    check("miss_ferr_pulse", frame_err, 1'b1);
    collect();
    check("miss_ferr_once", ferr_pulses - ferr_base, 32'd1);
    check_pkt(8'h05, "miss");

    // Out-of-range addresses ignored; duplicate address last write wins.
    ferr_base = ferr_pulses;
    for (int i = 0; i < 24; i++) begin
      d[i] = 8'h30 + 8'(i);
      if (i == 7) put(6'd7, 8'hEE);
      if (i == 12) begin
        put(6'd40, 8'hC3);
        put(6'd24, 8'hC4);
        put(6'd63, 8'hC5);
        check("oor_no_commit", tx_empty, 1'b1);
      end
      put(6'(i), d[i]);
    end
    collect();
    check("oor_no_ferr", ferr_pulses - ferr_base, 32'd0);
    check_pkt(8'h06, "oor");

    // Reset during DATA byte 10 aborts at once; sequence restarts at 0.
    put_frame(8'h50);
    tx_rdreq = 1'b1;
    repeat (13) step();
    tx_rdreq = 1'b0;
    check("abort_at_data10", tx_data, d[10]);
    #3;
    reset_n = 1'b0;
    #1;
    check("abort_empty", tx_empty, 1'b1);
    check("abort_busy", busy, 1'b0);
    step();
    reset_n = 1'b1;
    tx_rdreq = 1'b1;
    repeat (3) step();
    tx_rdreq = 1'b0;
    check("abort_no_partial", tx_empty, 1'b1);
    check("abort_ovr_clr", overrun_cnt, 8'd0);
    put_frame(8'h01);
    collect();
    check_pkt(8'h00, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/scan_frame_packer.md
Name: scan_frame_packer

Overview:
- Sits between the channel-scan controller and the UART byte transmitter.
- Collects one 8-bit sample per scanned channel into ping-pong frame buffers.
- Wraps each complete scan as a framed packet: header, sequence number, NUM_CH data bytes, check byte.
- Presents the packet through a show-ahead FIFO-style read port (data/empty/rdreq), so the UART transmitter consumes it unchanged.

Parameters:
- NUM_CH, 24: channels per scan frame; legal range 1..63; channel addresses 0..NUM_CH-1.
- HDR0, 8'hAA: first header byte.
- HDR1, 8'h55: second header byte.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous reset, active low.
- sample_valid  input  1  one-cycle strobe; sample_addr/sample_data are valid.
- sample_addr  input  6  channel address of the sample.
- sample_data  input  8  sample value (ADC code bits 7:0).
- tx_rdreq  input  1  pop current tx_data; ignored when tx_empty=1.
- tx_data  output  8  current packet byte; valid while tx_empty=0.
- tx_empty  output  1  1 = no byte available.
- busy  output  1  1 = packet transmission in progress.
- overrun_cnt  output  8  frames dropped because the sender was busy; saturates at 255.
- frame_err  output  1  one-cycle pulse at commit when any channel was missing from the frame.

Behaviour:
- Reset values: tx_empty=1, tx_data=0, busy=0, overrun_cnt=0, frame_err=0, seq=0, cap_sel=0, valid mask=0, FSM=IDLE. Buffer contents are undefined after reset.
- Reset is asynchronous. Asserting it mid-packet aborts the packet immediately; no partial bytes follow release.
- Capture:
  - sample_valid with sample_addr>=NUM_CH: ignored.
  - sample_addr==0: clears the valid mask, then writes byte 0.
  - Otherwise: writes buf[cap_sel][addr] and sets mask[addr]. A duplicate addr overwrites; last write wins.
- Commit occurs on the cycle a sample with addr==NUM_CH-1 is written. frame_err pulses the next cycle if the mask, including this write, is not all ones. The frame is sent regardless; missing bytes carry stale contents.
- Commit with sender IDLE, or releasing in this same cycle (CSUM popped this cycle):
  - Sender takes buf[cap_sel] and cap_sel toggles.
  - FSM enters HDR0 the next cycle: tx_empty=0, tx_data=HDR0.
  - Latency from the last-sample strobe to the first byte available is 1 cycle.
- Commit with sender busy: frame dropped, overrun_cnt+1 (saturating), cap_sel unchanged so the buffer is reused, mask cleared.
- Sender FSM: IDLE -> HDR0 -> HDR1 -> SEQ -> DATA (index 0..NUM_CH-1) -> CSUM -> IDLE.
  - Each state advances only on a cycle with tx_rdreq=1 and tx_empty=0.
  - The next byte appears on tx_data the following cycle.
  - tx_rdreq held high gives one byte per cycle.
- Packet length is NUM_CH+4 bytes. busy=1 from HDR0 through CSUM.
- seq:
  - 8-bit, emitted in SEQ.
  - Increments when CSUM is popped; 255 wraps to 0.
  - Dropped frames do not consume a sequence number.
- Check byte: (seq + sum of all data bytes) mod 256. HDR bytes are excluded.
- The check byte is accumulated as data is popped, not precomputed. Byte DATA[k] reads the send buffer combinationally or through a registered read; either is acceptable if the show-ahead timing above holds.
- Capture into the non-sending buffer continues during transmission.

Optional Feature:
- Macro FRAME_CRC8_EN.
- Defined: the check byte is CRC-8 over seq then the data bytes, polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
- Undefined: the additive mod-256 checksum above.
- Packet length and timing are identical in both cases.

Test Plan:
- Reset, then write addr 0..23 with data=addr+1, tx_rdreq held 1 -> bytes AA 55 00 01..18 then check byte 0x2C (sum 300 mod 256); busy high for 28 cycles; frame_err stays 0.
- Second identical frame after the first completes -> seq byte 01, check byte 0x2D; third frame seq 02.
- Complete a second frame while the first is still sending (tx_rdreq held 0) -> overrun_cnt=1; after draining, exactly one packet observed; the next committed frame carries seq 01.
- Frame omitting addr 5 -> frame_err one-cycle pulse 1 cycle after commit; packet is still 28 bytes.
- Sample with addr=40 injected mid-frame -> no buffer change; packet bytes unaffected. Reset asserted at DATA byte 10 -> tx_empty=1 immediately; next frame carries seq 00.
- FRAME_CRC8_EN build, seq=0, data bytes 01..18 -> check byte equals reference CRC-8/0x07 over 00,01..18; header and length unchanged.
